// File: rtl/gray_fifo_pkg.sv
// Shared definitions for the Gray-pointer FIFO: FSM encoding, pointer width
// and Gray/binary conversion helpers used by both FIFO sides.
`timescale 1ns/1ps
package gray_fifo_pkg;

    localparam int   PTR_BITS = 3;
    localparam logic ST_INIT  = 1'b0;
    localparam logic ST_RUN   = 1'b1;

    typedef logic [PTR_BITS-1:0] ptr_t;

    function automatic ptr_t bin2gray(input ptr_t b);
        return b ^ {1'b0, b[PTR_BITS-1:1]};
    endfunction

    function automatic ptr_t gray2bin(input ptr_t g);
        ptr_t b;
        b[PTR_BITS-1] = g[PTR_BITS-1];
        for (int i = PTR_BITS - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    // Successor in the Gray sequence; always differs from g in exactly one bit.
    function automatic ptr_t gray_next(input ptr_t g);
        return bin2gray(gray2bin(g) + 3'd1);
    endfunction

endpackage

// File: rtl/gray_fifo_wr_ctrl_if.sv
// Write-side bundle of the Gray FIFO. With GRAY_FIFO_OVERFLOW_FLAG_EN defined
// the bundle also carries the sticky overflow flag.
`timescale 1ns/1ps
interface gray_fifo_wr_ctrl_if
    import gray_fifo_pkg::*;
#(
    parameter int D_BITS = 32
);
    logic              put;
    logic [D_BITS-1:0] din;
    logic              full;
    logic              almost_full;
    logic              wr_en;
    ptr_t              wr_addr;
    logic [D_BITS-1:0] wr_data;
    ptr_t              cnt_wr;
    ptr_t              rd_ptr_async;
    ptr_t              cnt_rd;
    logic              cmp_full;
    logic              cmp_high;
`ifdef GRAY_FIFO_OVERFLOW_FLAG_EN
    logic              overflow;
`endif

    // Environment side: user, RAM, comparator and read-domain pointer.
    modport master (
        output put, din, rd_ptr_async, cmp_full, cmp_high,
        input  full, almost_full, wr_en, wr_addr, wr_data, cnt_wr, cnt_rd
`ifdef GRAY_FIFO_OVERFLOW_FLAG_EN
        , input overflow
`endif
    );

    // Write controller side.
    modport slave (
        input  put, din, rd_ptr_async, cmp_full, cmp_high,
        output full, almost_full, wr_en, wr_addr, wr_data, cnt_wr, cnt_rd
`ifdef GRAY_FIFO_OVERFLOW_FLAG_EN
        , output overflow
`endif
    );

endinterface

// File: rtl/gray_ptr_sync.sv
// Multi-stage flop synchroniser for a Gray pointer crossing clock domains.
// Shared by the write and read controllers.
`timescale 1ns/1ps
module gray_ptr_sync
    import gray_fifo_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  ptr_t ptr_async,
    output ptr_t ptr_sync
);

    ptr_t chain_r [SYNC_STAGES];

    // Shift the foreign pointer through the synchroniser stages.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                chain_r[i] <= '0;
            end
        end else begin
            chain_r[0] <= ptr_async;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                chain_r[i] <= chain_r[i-1];
            end
        end
    end

    assign ptr_sync = chain_r[SYNC_STAGES-1];

endmodule

// File: rtl/gray_fifo_wr_ctrl.sv
// Write-side controller of the 8-slot Gray-pointer FIFO. Optional sticky
// overflow flag is enabled by defining GRAY_FIFO_OVERFLOW_FLAG_EN.
`timescale 1ns/1ps
module gray_fifo_wr_ctrl
    import gray_fifo_pkg::*;
#(
    parameter int D_BITS      = 32,
    parameter int SYNC_STAGES = 2
) (
    input  logic                Clock,
    input  logic                Reset,
    gray_fifo_wr_ctrl_if.slave  bus
);

    // Counter is wide enough for the deepest synchroniser (4 stages).
    localparam logic [2:0] INIT_LAST = 3'(SYNC_STAGES);

    logic              state_r;
    logic              state_nxt_s;
    logic [2:0]        init_cnt_r;
    ptr_t              cnt_wr_r;
    ptr_t              cnt_rd_s;
    logic              full_s;
    logic              almost_full_s;
    logic              accept_s;
    logic [D_BITS-1:0] din_s;

    gray_ptr_sync #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_rd_sync (
        .clk       (Clock),
        .rst       (Reset),
        .ptr_async (bus.rd_ptr_async),
        .ptr_sync  (cnt_rd_s)
    );

    // State register plus the INIT flush counter.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_r    <= ST_INIT;
            init_cnt_r <= 3'd0;
        end else begin
            state_r <= state_nxt_s;
            if (state_r == ST_INIT) begin
                init_cnt_r <= init_cnt_r + 3'd1;
            end else begin
                init_cnt_r <= init_cnt_r;
            end
        end
    end

    // Leave INIT only once the synchroniser holds a trustworthy read pointer.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_INIT: begin
                if (init_cnt_r == INIT_LAST) begin
                    state_nxt_s = ST_RUN;
                end else begin
                    state_nxt_s = ST_INIT;
                end
            end
            ST_RUN:  state_nxt_s = ST_RUN;
            default: state_nxt_s = ST_INIT;
        endcase
    end

    // Status outputs: pessimistic (full) while INIT, comparator flags in RUN.
    always_comb begin
        full_s        = 1'b1;
        almost_full_s = 1'b1;
        case (state_r)
            ST_RUN: begin
                full_s        = bus.cmp_full;
                almost_full_s = bus.cmp_high;
            end
            ST_INIT: begin
                full_s        = 1'b1;
                almost_full_s = 1'b1;
            end
            default: begin
                full_s        = 1'b1;
                almost_full_s = 1'b1;
            end
        endcase
    end

    assign accept_s = bus.put & ~full_s;

    // Pointer advances on the same edge the RAM captures the word.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            cnt_wr_r <= '0;
        end else if (accept_s) begin
            cnt_wr_r <= gray_next(cnt_wr_r);
        end else begin
            cnt_wr_r <= cnt_wr_r;
        end
    end

`ifdef GRAY_FIFO_OVERFLOW_FLAG_EN
    logic overflow_r;

    // Sticky record of a put rejected while running.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            overflow_r <= 1'b0;
        end else if ((state_r == ST_RUN) && bus.put && full_s) begin
            overflow_r <= 1'b1;
        end else begin
            overflow_r <= overflow_r;
        end
    end

    assign bus.overflow = overflow_r;
`endif

    assign din_s           = bus.din;
    assign bus.full        = full_s;
    assign bus.almost_full = almost_full_s;
    assign bus.wr_en       = accept_s;
    assign bus.wr_addr     = gray2bin(cnt_wr_r);
    assign bus.wr_data     = din_s;
    assign bus.cnt_wr      = cnt_wr_r;
    assign bus.cnt_rd      = cnt_rd_s;

endmodule

// File: tb/tb_gray_fifo_wr_ctrl.sv
// Scoreboard bench for gray_fifo_wr_ctrl: directed put/read sequences with
// hand-computed write expectations checked by an independent write monitor.
`timescale 1ns/1ps
module tb_gray_fifo_wr_ctrl;

    localparam int S = 2;

    typedef struct packed {
        logic [2:0]  addr;
        logic [31:0] data;
    } wr_exp_t;

    logic    Clock = 1'b0;
    logic    Reset;
    int      checks = 0;
    int      errors = 0;
    wr_exp_t exp_q [$];

    logic [2:0] gray_tab [8] = '{3'b000, 3'b001, 3'b011, 3'b010,
                                 3'b110, 3'b111, 3'b101, 3'b100};

    gray_fifo_wr_ctrl_if #(.D_BITS(32)) bus ();

    gray_fifo_wr_ctrl #(
        .D_BITS      (32),
        .SYNC_STAGES (S)
    ) dut (
        .Clock (Clock),
        .Reset (Reset),
        .bus   (bus.slave)
    );

    always #5 Clock = ~Clock;

    function automatic int g2b(input logic [2:0] g);
        for (int i = 0; i < 8; i++) begin
            if (gray_tab[i] == g) return i;
        end
        return 0;
    endfunction

    // Reference comparator: occupancy from the two Gray pointers.
    int occ;
    always_comb begin
        occ = (g2b(bus.cnt_wr) - g2b(bus.cnt_rd) + 8) % 8;
    end
    assign bus.cmp_full = (occ == 7);
    assign bus.cmp_high = (occ >= 6);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic rst, input logic put, input logic [31:0] din,
                         input logic [2:0] rd);
        @(posedge Clock);
        #1;
        Reset            = rst;
        bus.put          = put;
        bus.din          = din;
        bus.rd_ptr_async = rd;
    endtask

    task automatic expect_write(input int addr, input logic [31:0] data);
        wr_exp_t e;
        e.addr = addr[2:0];
        e.data = data;
        exp_q.push_back(e);
    endtask

    // Write monitor: every RAM write must match the next expected entry.
    initial begin
        wr_exp_t e;
        forever begin
            @(negedge Clock);
            if (bus.wr_en === 1'b1) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_write: wr_addr=%0d wr_data=%0h, no write expected",
                             bus.wr_addr, bus.wr_data);
                end else begin
                    e = exp_q.pop_front();
                    chk("wr_addr", 32'(bus.wr_addr), 32'(e.addr));
                    chk("wr_data", bus.wr_data, e.data);
                    chk("cnt_wr_at_write", 32'(bus.cnt_wr), 32'(gray_tab[e.addr]));
                end
            end
        end
    end

    // Pointer-step monitor: outside reset, cnt_wr may only move to its Gray successor.
    initial begin
        logic [2:0] prev_wr;
        logic       prev_rst;
        bit         have_prev;
        have_prev = 1'b0;
        forever begin
            @(negedge Clock);
            if (have_prev && (prev_rst === 1'b0) && (bus.cnt_wr !== prev_wr)) begin
                chk("gray_step", 32'(bus.cnt_wr), 32'(gray_tab[(g2b(prev_wr) + 1) % 8]));
                chk("hamming_1", 32'($countones(bus.cnt_wr ^ prev_wr)), 32'd1);
            end
            prev_wr   = bus.cnt_wr;
            prev_rst  = Reset;
            have_prev = 1'b1;
        end
    end

    initial begin
        logic [31:0] d;
        Reset            = 1'b1;
        bus.put          = 1'b0;
        bus.din          = 32'h0;
        bus.rd_ptr_async = 3'b000;

        // Reset state
        repeat (2) @(posedge Clock);
        @(negedge Clock);
        chk("rst_cnt_wr", 32'(bus.cnt_wr), 32'd0);
        chk("rst_cnt_rd", 32'(bus.cnt_rd), 32'd0);
        chk("rst_full", 32'(bus.full), 32'd1);
        chk("rst_almost_full", 32'(bus.almost_full), 32'd1);
        chk("rst_wr_en", 32'(bus.wr_en), 32'd0);
`ifdef GRAY_FIFO_OVERFLOW_FLAG_EN
        chk("rst_overflow", 32'(bus.overflow), 32'd0);
`endif

        // Continuous put from empty: INIT for S+1 cycles, then 7 accepts.
        for (int c = 0; c < 12; c++) begin
            d = 32'hA500_0000 | 32'(c);
            drive(1'b0, 1'b1, d, 3'b000);
            if (c >= S + 1 && c <= S + 7) expect_write(c - (S + 1), d);
            @(negedge Clock);
            if (c <= S) begin
                chk("init_full", 32'(bus.full), 32'd1);
                chk("init_almost_full", 32'(bus.almost_full), 32'd1);
            end else if (c <= S + 7) begin
                chk("run_full", 32'(bus.full), 32'd0);
                chk("run_almost_full", 32'(bus.almost_full),
                    ((c - (S + 1)) >= 6) ? 32'd1 : 32'd0);
            end else begin
                chk("full_after_7", 32'(bus.full), 32'd1);
                chk("almost_full_at_full", 32'(bus.almost_full), 32'd1);
                chk("cnt_wr_full", 32'(bus.cnt_wr), 32'b100);
            end
`ifdef GRAY_FIFO_OVERFLOW_FLAG_EN
            if (c == S + 1) chk("ovf_not_in_init", 32'(bus.overflow), 32'd0);
            if (c == S + 8) chk("ovf_before_drop", 32'(bus.overflow), 32'd0);
            if (c == S + 9) chk("ovf_set", 32'(bus.overflow), 32'd1);
`endif
        end

        // One read frees one slot after the synchroniser delay.
        for (int c = 0; c <= S + 1; c++) begin
            d = 32'hB000_0000 | 32'(c);
            drive(1'b0, 1'b1, d, 3'b001);
            if (c == S) expect_write(7, d);
            @(negedge Clock);
            if (c < S) begin
                chk("full_during_sync", 32'(bus.full), 32'd1);
                chk("cnt_rd_delayed", 32'(bus.cnt_rd), 32'd0);
            end else if (c == S) begin
                chk("full_falls", 32'(bus.full), 32'd0);
                chk("cnt_rd_synced", 32'(bus.cnt_rd), 32'b001);
            end else begin
                chk("full_again", 32'(bus.full), 32'd1);
                chk("cnt_wr_wrapped", 32'(bus.cnt_wr), 32'b000);
            end
        end

        // Wrap: 8 reads, each releasing exactly one write (addr 0..7).
        for (int j = 0; j < 8; j++) begin
            for (int k = 0; k <= S; k++) begin
                d = 32'hC000_0000 | 32'(j << 4) | 32'(k);
                drive(1'b0, 1'b1, d, gray_tab[(2 + j) % 8]);
                if (k == S) expect_write(j, d);
                @(negedge Clock);
                chk("wrap_full", 32'(bus.full), (k == S) ? 32'd0 : 32'd1);
            end
        end
        drive(1'b0, 1'b0, 32'h0, 3'b001);
        @(negedge Clock);
        chk("wrap_cnt_wr", 32'(bus.cnt_wr), 32'b000);
        chk("wrap_full_end", 32'(bus.full), 32'd1);
`ifdef GRAY_FIFO_OVERFLOW_FLAG_EN
        chk("ovf_sticky", 32'(bus.overflow), 32'd1);
`endif

        // Reset both sides, burst to cnt_wr=011, then reset mid-burst.
        drive(1'b1, 1'b0, 32'h0, 3'b000);
        for (int c = 0; c < 11; c++) begin
            d = 32'hD000_0000 | 32'(c);
            if (c == 2 * S + 1) begin
                drive(1'b1, 1'b0, d, 3'b000);
            end else if (c >= S + 1 && c < 2 * S + 1) begin
                drive(1'b0, 1'b1, d, 3'b001);
            end else begin
                drive(1'b0, (c < 10) ? 1'b1 : 1'b0, d, 3'b000);
            end
            if (c == S + 1 || c == S + 2 || c == 2 * S + 5) expect_write(c < 2 * S + 5 ? c - (S + 1) : 0, d);
            @(negedge Clock);
`ifdef GRAY_FIFO_OVERFLOW_FLAG_EN
            if (c == 0) chk("ovf_cleared", 32'(bus.overflow), 32'd0);
`endif
            if (c == 2 * S + 1) begin
                chk("burst_cnt_wr", 32'(bus.cnt_wr), 32'b011);
                chk("burst_cnt_rd", 32'(bus.cnt_rd), 32'b001);
            end
            if (c == 2 * S + 2) begin
                chk("mid_rst_cnt_wr", 32'(bus.cnt_wr), 32'd0);
                chk("mid_rst_cnt_rd", 32'(bus.cnt_rd), 32'd0);
                chk("mid_rst_almost_full", 32'(bus.almost_full), 32'd1);
            end
            if (c >= 2 * S + 2 && c <= 3 * S + 2) chk("mid_rst_init_full", 32'(bus.full), 32'd1);
        end

        drive(1'b0, 1'b0, 32'h0, 3'b000);
        @(negedge Clock);
        chk("missing_writes", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
